// File: rtl/ddr3_wr_buffer_pkg.sv
// Purpose: shared constants, helper function and FSM state type for the DDR3 write-data buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ddr3_wr_buffer_pkg;

  // Beats per DDR3 BL8 burst for an x16 device at a 2:1 controller clock ratio.
  localparam int BEATS_PER_BL8 = 4;

  // Ceiling log2. It is used only for elaboration-time widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Input-side fill state.
  // FILL accepts AXI beats.
  // PAD writes masked filler beats to complete a short burst.
  typedef enum logic {
    FILL = 1'b0,
    PAD  = 1'b1
  } fill_state_t;

endpackage

// File: rtl/ddr3_wr_buffer_store.sv
// Purpose: BURSTS*BEATS beat register file holding {mask, data} for the write buffer.
// Latency: write lands on the next clock edge; read is combinational from the index (FWFT).
// Backpressure: none; the caller only writes into slots it owns.
//
// Ports:
//   clock                   storage clock
//   write_en/index          registered write port select
//   write_mask/data         beat contents to store
//   read_index              combinational read select
//   read_mask/data          beat contents at read_index
module ddr3_wr_store
  import ddr3_wr_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MASKS  = WIDTH / 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_index,
  input  logic [MASKS-1:0]  write_mask,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_index,
  output logic [MASKS-1:0]  read_mask,
  output logic [WIDTH-1:0]  read_data
);

  // The contents are don't-care until written, so the array has no reset.
  // Slot ownership is tracked by the pointer logic in the parent module.
  logic [MASKS+WIDTH-1:0] cells [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      cells[write_index] <= {write_mask, write_data};
    end
  end

  assign {read_mask, read_data} = cells[read_index];

endmodule

// File: rtl/ddr3_wr_buffer.sv
// Purpose: burst-granular write-data buffer feeding ddr3_ddl.
//   It packs AXI W beats into whole BL8 bursts, pads short bursts and splits overlong ones.
// Latency: a burst is offered on mem_w* the cycle after its final beat is written.
// Backpressure: axi_wready_o drops while padding, or when every burst slot is committed.
//   mem_wvalid_o holds until mem_wready_i.
//
// Ports:
//   clock, reset              system clock; synchronous active-high reset
//   axi_wvalid_i/wready_o     AXI W beat handshake
//   axi_wlast_i/wstrb_i/wdata_i   AXI beat contents
//   mem_wvalid_o/wready_i     burst-beat handshake to ddr3_ddl
//   mem_wlast_o/wrmask_o/wrdata_o beat contents to ddr3_ddl
//   bursts_o                  committed bursts held
//   err_o                     one-cycle pulse when a burst filled without axi_wlast_i on its last beat
module ddr3_wr_buffer
  import ddr3_wr_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MASKS  = WIDTH / 8,
  parameter int BEATS  = BEATS_PER_BL8,
  parameter int BURSTS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic                    axi_wlast_i,
  input  logic [MASKS-1:0]        axi_wstrb_i,
  input  logic [WIDTH-1:0]        axi_wdata_i,
  output logic                    mem_wvalid_o,
  input  logic                    mem_wready_i,
  output logic                    mem_wlast_o,
  output logic [MASKS-1:0]        mem_wrmask_o,
  output logic [WIDTH-1:0]        mem_wrdata_o,
  output logic [clog2(BURSTS):0]  bursts_o,
  output logic                    err_o
);

  localparam int BEAT_W = clog2(BEATS);
  localparam int SLOT_W = clog2(BURSTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BURSTS);

  fill_state_t       state_q, state_d;
  logic [BEAT_W-1:0] wr_beat_q, wr_beat_d;
  logic [SLOT_W-1:0] wr_burst_q, wr_burst_d;
  logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;
  logic [SLOT_W-1:0] rd_burst_q, rd_burst_d;
  logic [CNT_W-1:0]  bursts_q, bursts_d;
  logic              err_q, err_d;

  logic              beat_in;
  logic              commit;
  logic              drain;
  logic              drain_done;
  logic              store_we;
  logic [MASKS-1:0]  store_mask;
  logic [WIDTH-1:0]  store_data;

  // A burst that is already in progress owns its slot, so it may always complete.
  // Opening a new burst needs a free slot, which exists only while fewer than
  // BURSTS bursts are committed.
  assign axi_wready_o = !reset && (state_q == FILL) &&
                        ((wr_beat_q != '0) || (bursts_q != FULL_CNT));

  assign beat_in      = axi_wvalid_i && axi_wready_o;
  assign mem_wvalid_o = (bursts_q != '0);

  // mem_wlast_o is derived from the read counter, so it cannot drift from the beat position.
  assign mem_wlast_o  = mem_wvalid_o && (rd_beat_q == LAST_BEAT);
  assign drain        = mem_wvalid_o && mem_wready_i;
  assign drain_done   = drain && (rd_beat_q == LAST_BEAT);
  assign bursts_o     = bursts_q;
  assign err_o        = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      wr_beat_q  <= '0;
      wr_burst_q <= '0;
      rd_beat_q  <= '0;
      rd_burst_q <= '0;
      bursts_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_beat_q  <= wr_beat_d;
      wr_burst_q <= wr_burst_d;
      rd_beat_q  <= rd_beat_d;
      rd_burst_q <= rd_burst_d;
      bursts_q   <= bursts_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_beat_d  = wr_beat_q;
    wr_burst_d = wr_burst_q;
    rd_beat_d  = rd_beat_q;
    rd_burst_d = rd_burst_q;
    store_we   = 1'b0;
    store_mask = '0;
    store_data = '0;
    commit     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      FILL: begin
        if (beat_in) begin
          store_we   = 1'b1;
          store_mask = axi_wstrb_i;
          store_data = axi_wdata_i;
          wr_beat_d  = wr_beat_q + 1'b1;
          if (wr_beat_q == LAST_BEAT) begin
            // The burst is full. An AXI burst that is still open continues in a
            // fresh BL8 burst and is flagged as split.
            commit = 1'b1;
            err_d  = !axi_wlast_i;
          end else if (axi_wlast_i) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        // The filler beats are fully masked, so ddr3_ddl writes no bytes for them.
        store_we  = 1'b1;
        wr_beat_d = wr_beat_q + 1'b1;
        if (wr_beat_q == LAST_BEAT) begin
          commit  = 1'b1;
          state_d = FILL;
        end
      end
    endcase

    if (commit) begin
      wr_burst_d = wr_burst_q + 1'b1;
    end

    if (drain) begin
      rd_beat_d = rd_beat_q + 1'b1;
      if (drain_done) begin
        rd_burst_d = rd_burst_q + 1'b1;
      end
    end

    // A commit and a drain completion in the same cycle cancel out.
    // With one burst held, this keeps mem_wvalid_o steady.
    bursts_d = bursts_q + CNT_W'(commit) - CNT_W'(drain_done);
  end

  ddr3_wr_store #(
    .WIDTH  (WIDTH),
    .MASKS  (MASKS),
    .DEPTH  (BURSTS * BEATS),
    .ADDR_W (SLOT_W + BEAT_W)
  ) u_store (
    .clock       (clock),
    .write_en    (store_we),
    .write_index ({wr_burst_q, wr_beat_q}),
    .write_mask  (store_mask),
    .write_data  (store_data),
    .read_index  ({rd_burst_q, rd_beat_q}),
    .read_mask   (mem_wrmask_o),
    .read_data   (mem_wrdata_o)
  );

endmodule
